// File: rtl/return_address_stack_if.sv
// Fetch <-> return-address-stack signal bundle: push/pop/recover requests in, prediction and checkpoint out.
// Checkpoint width grows by XLEN when RAS_REPAIR_TOP_EN is defined.
interface return_address_stack_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef RAS_REPAIR_TOP_EN
  localparam int CKPT_W = 2*PTR_W + 1 + XLEN;
`else
  localparam int CKPT_W = 2*PTR_W + 1;
`endif

  logic              push;
  logic [XLEN-1:0]   push_addr;
  logic              pop;
  logic [XLEN-1:0]   ras_target;
  logic              ras_valid;
  logic [CKPT_W-1:0] ckpt_out;
  logic              recover;
  logic [CKPT_W-1:0] ckpt_in;

  modport master (
    output push, push_addr, pop, recover, ckpt_in,
    input  ras_target, ras_valid, ckpt_out
  );

  modport slave (
    input  push, push_addr, pop, recover, ckpt_in,
    output ras_target, ras_valid, ckpt_out
  );
endinterface

// File: rtl/return_address_stack.sv
// Circular return-address stack feeding the fetch next-PC mux, with {tos,count} checkpoint/recover.
// Optional RAS_REPAIR_TOP_EN: checkpoint also carries the top entry, rewritten on recover.
module return_address_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  return_address_stack_if.slave  ras
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  stack_q [DEPTH];

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [XLEN-1:0]  wr_data;

  logic [PTR_W-1:0] ck_tos;
  logic [CNT_W-1:0] ck_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == FULL) ? c : c + 1'b1;
  endfunction

  assign ck_tos = ras.ckpt_in[2*PTR_W:PTR_W+1];
  assign ck_cnt = ras.ckpt_in[PTR_W:0];

`ifdef RAS_REPAIR_TOP_EN
  logic [XLEN-1:0] ck_top;
  assign ck_top       = ras.ckpt_in[2*PTR_W+1 +: XLEN];
  assign ras.ckpt_out = {stack_q[tos_q], tos_q, count_q};
`else
  assign ras.ckpt_out = {tos_q, count_q};
`endif

  assign ras.ras_valid  = (count_q != '0);
  assign ras.ras_target = (count_q != '0) ? stack_q[tos_q] : '0;

  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = ras.push_addr;
    if (ras.recover) begin
      tos_d   = ck_tos;
      count_d = ck_cnt;
`ifdef RAS_REPAIR_TOP_EN
      wr_en   = 1'b1;
      wr_idx  = ck_tos;
      wr_data = ck_top;
`endif
    end else if (ras.push && ras.pop) begin
      // Return-then-call replaces the top in place; an empty stack gains one entry.
      wr_en = 1'b1;
      if (count_q == '0) count_d = CNT_W'(1);
    end else if (ras.push) begin
      tos_d   = tos_q + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = tos_q + 1'b1;
      count_d = sat_inc(count_q);
    end else if (ras.pop && (count_q != '0)) begin
      tos_d   = tos_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      tos_q   <= '0;
      count_q <= '0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  // Entry RAM has no reset; writes are suppressed while reset is held so in-flight pushes are dropped.
  always_ff @(posedge CLK) begin
    if (wr_en && reset_n) stack_q[wr_idx] <= wr_data;
  end
endmodule

// File: tb/tb_return_address_stack.sv
// Directed + random bench for return_address_stack against a ring-buffer reference model.
module tb_return_address_stack;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
`ifdef RAS_REPAIR_TOP_EN
  localparam int CKPT_W = 2*PTR_W + 1 + XLEN;
`else
  localparam int CKPT_W = 2*PTR_W + 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  return_address_stack_if #(.XLEN(XLEN), .DEPTH(DEPTH)) ras_if ();

  return_address_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .reset_n (rst_n),
    .ras     (ras_if.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: ring of DEPTH slots, top index and occupancy as plain integers.
  logic [XLEN-1:0] m_mem [DEPTH];
  bit              m_wr  [DEPTH];
  int              m_tos;
  int              m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CKPT_W-1:0] m_ckpt();
    logic [PTR_W-1:0] t;
    logic [PTR_W:0]   c;
    t = m_tos[PTR_W-1:0];
    c = m_cnt[PTR_W:0];
`ifdef RAS_REPAIR_TOP_EN
    return {m_mem[m_tos], t, c};
`else
    return {t, c};
`endif
  endfunction

  function automatic int dut_cnt();
    return int'(ras_if.ckpt_out[PTR_W:0]);
  endfunction

  function automatic int dut_tos();
    return int'(ras_if.ckpt_out[2*PTR_W:PTR_W+1]);
  endfunction

  task automatic check_state(input string tag);
    logic [CKPT_W-1:0] e;
    logic [2*PTR_W:0]  e_lo;
    logic [2*PTR_W:0]  o_lo;
    e    = m_ckpt();
    e_lo = e[2*PTR_W:0];
    o_lo = ras_if.ckpt_out[2*PTR_W:0];
    chk({tag, ".valid"}, 64'(ras_if.ras_valid), 64'(m_cnt != 0));
    chk({tag, ".target"}, 64'(ras_if.ras_target), (m_cnt != 0) ? 64'(m_mem[m_tos]) : 64'd0);
    if (m_wr[m_tos]) chk({tag, ".ckpt"}, 64'(ras_if.ckpt_out), 64'(e));
    else             chk({tag, ".ckpt_ptr"}, 64'(o_lo), 64'(e_lo));
  endtask

  task automatic cyc(input string tag, input bit pu, input logic [XLEN-1:0] a,
                     input bit po, input bit rc, input logic [CKPT_W-1:0] ck);
    ras_if.push      = pu;
    ras_if.push_addr = a;
    ras_if.pop       = po;
    ras_if.recover   = rc;
    ras_if.ckpt_in   = ck;
    #1;
    check_state(tag);
    @(posedge clk);
    if (rc) begin
      m_tos = int'(ck[2*PTR_W:PTR_W+1]);
      m_cnt = int'(ck[PTR_W:0]);
`ifdef RAS_REPAIR_TOP_EN
      m_mem[m_tos] = ck[2*PTR_W+1 +: XLEN];
      m_wr[m_tos]  = 1'b1;
`endif
    end else if (pu && po) begin
      m_mem[m_tos] = a;
      m_wr[m_tos]  = 1'b1;
      if (m_cnt == 0) m_cnt = 1;
    end else if (pu) begin
      m_tos        = (m_tos + 1) % DEPTH;
      m_mem[m_tos] = a;
      m_wr[m_tos]  = 1'b1;
      if (m_cnt < DEPTH) m_cnt++;
    end else if (po && m_cnt > 0) begin
      m_tos = (m_tos + DEPTH - 1) % DEPTH;
      m_cnt--;
    end
    #2;
  endtask

  logic [CKPT_W-1:0] saved;
  logic [CKPT_W-1:0] pool [$];
  bit pu, po, rc;

  initial begin
    rst_n            = 1'b0;
    ras_if.push      = 1'b0;
    ras_if.push_addr = '0;
    ras_if.pop       = 1'b0;
    ras_if.recover   = 1'b0;
    ras_if.ckpt_in   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 1'b0;
    end
    m_tos = 0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.valid", 64'(ras_if.ras_valid), 64'd0);
    chk("rst.target", 64'(ras_if.ras_target), 64'd0);
    chk("rst.ckpt", 64'(ras_if.ckpt_out[2*PTR_W:0]), 64'd0);
    #1 rst_n = 1'b1;

    // Three pushes then a pop
    cyc("p100", 1, 32'h100, 0, 0, '0);
    cyc("p200", 1, 32'h200, 0, 0, '0);
    cyc("p300", 1, 32'h300, 0, 0, '0);
    chk("t1.top", 64'(ras_if.ras_target), 64'h300);
    cyc("pop1", 0, '0, 1, 0, '0);
    chk("t1.after_pop", 64'(ras_if.ras_target), 64'h200);
    chk("t1.count", 64'(dut_cnt()), 64'd2);
    cyc("drain1", 0, '0, 1, 0, '0);
    cyc("drain2", 0, '0, 1, 0, '0);

    // Overflow wrap
    for (int i = 1; i <= 9; i++) cyc("ovf.push", 1, XLEN'(i * 16), 0, 0, '0);
    chk("ovf.count", 64'(dut_cnt()), 64'd8);
    chk("ovf.top", 64'(ras_if.ras_target), 64'h90);
    for (int i = 0; i < 8; i++) begin
      chk("ovf.popval", 64'(ras_if.ras_target), 64'(32'h90 - 32'(16 * i)));
      cyc("ovf.pop", 0, '0, 1, 0, '0);
    end
    chk("ovf.empty", 64'(ras_if.ras_valid), 64'd0);
    cyc("ovf.pop_empty", 0, '0, 1, 0, '0);
    chk("ovf.empty_cnt", 64'(dut_cnt()), 64'd0);
    chk("ovf.empty_tos", 64'(dut_tos()), 64'd1);

    // Simultaneous push+pop
    cyc("pp.p400", 1, 32'h400, 0, 0, '0);
    chk("pp.old_top", 64'(ras_if.ras_target), 64'h400);
    cyc("pp.both", 1, 32'h500, 1, 0, '0);
    chk("pp.new_top", 64'(ras_if.ras_target), 64'h500);
    chk("pp.count", 64'(dut_cnt()), 64'd1);

    // Recover after wrong-path pop+pushes
    cyc("rc.p600", 1, 32'h600, 0, 0, '0);
    saved = m_ckpt();
    chk("rc.ckpt_ptr", 64'(ras_if.ckpt_out[2*PTR_W:0]), 64'({3'd3, 4'd2}));
    cyc("rc.pop", 0, '0, 1, 0, '0);
    cyc("rc.pA0", 1, 32'hA0, 0, 0, '0);
    cyc("rc.pB0", 1, 32'hB0, 0, 0, '0);
    cyc("rc.recover", 1, 32'hC0, 0, 1, saved);
    chk("rc.count", 64'(dut_cnt()), 64'd2);
    chk("rc.tos", 64'(dut_tos()), 64'd3);
`ifdef RAS_REPAIR_TOP_EN
    chk("rc.top", 64'(ras_if.ras_target), 64'h600);
`else
    chk("rc.top", 64'(ras_if.ras_target), 64'hA0);
`endif

    // Empty push+pop
    cyc("ep.pop1", 0, '0, 1, 0, '0);
    cyc("ep.pop2", 0, '0, 1, 0, '0);
    chk("ep.empty", 64'(dut_cnt()), 64'd0);
    cyc("ep.both", 1, 32'h44, 1, 0, '0);
    chk("ep.count", 64'(dut_cnt()), 64'd1);
    chk("ep.top", 64'(ras_if.ras_target), 64'h44);

    // Asynchronous reset between clock edges
    for (int i = 1; i <= 4; i++) cyc("ar.push", 1, XLEN'(32'h50 + i), 0, 0, '0);
    chk("ar.count5", 64'(dut_cnt()), 64'd5);
    #3 rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(ras_if.ras_valid), 64'd0);
    chk("ar.count", 64'(dut_cnt()), 64'd0);
    chk("ar.tos", 64'(dut_tos()), 64'd0);
    m_tos = 0;
    m_cnt = 0;
    ras_if.push      = 1'b1;
    ras_if.push_addr = 32'h77;
    @(posedge clk);
    #2;
    chk("ar.held", 64'(dut_cnt()), 64'd0);
    ras_if.push = 1'b0;
    rst_n = 1'b1;

    // Random traffic with checkpoints taken from the model
    for (int n = 0; n < 400; n++) begin
      if (($urandom % 8) == 0 && m_wr[m_tos]) pool.push_back(m_ckpt());
      pu = ($urandom % 2) == 1;
      po = ($urandom % 2) == 1;
      rc = (($urandom % 12) == 0) && (pool.size() != 0);
      saved = '0;
      if (rc) saved = pool[$urandom_range(0, pool.size() - 1)];
      cyc("rnd", pu, XLEN'($urandom) & ~XLEN'(3), po, rc, saved);
      if (pool.size() > 6) void'(pool.pop_front());
    end
    check_state("rnd.final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
